// File: rtl/clock_strobe_gen.sv
// ---------------------------------------------------------------------------
// clock_strobe_gen
//
// Clock-enable generator placed directly behind the PLL wrapper. It turns the
// PLL lock indication into a clean design reset and produces NUM_CH
// fractional-rate strobes, each from a run-time programmable phase
// accumulator. Downstream logic runs on the single PLL clock and uses the
// strobes as clock enables.
//
// Ports:
//   clock            PLL output clock, all logic on the rising edge
//   reset            synchronous, active-high
//   pll_locked       PLL lock, already synchronised to clock
//   rst_out          design reset, active-high, registered
//   cfg_valid        config request
//   cfg_ready        config port can accept (low while a request is pending)
//   cfg_ch           target channel (ignored when cfg_broadcast)
//   cfg_broadcast    apply the request to every channel
//   cfg_inc          phase increment
//   cfg_en           channel enable
//   cfg_phase_reset  clear the target accumulator(s) when applied
//   strobe           one-cycle clock-enable pulses, bit i = channel i
// ---------------------------------------------------------------------------
module clock_strobe_gen #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned ACC_W      = 24,
   parameter int unsigned RESET_HOLD = 16,
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              pll_locked,
   output logic              rst_out,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic              cfg_broadcast,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic              cfg_en,
   input  logic              cfg_phase_reset,
   output logic [NUM_CH-1:0] strobe
);

   // Counter only needs to reach RESET_HOLD-1.
   localparam int unsigned CNT_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESET_HOLD - 1);

   // ------------------------------------------------------------------------
   // Reset sequencer
   // ------------------------------------------------------------------------
   typedef enum logic [1:0] {StHold, StCount, StRun} seq_state_e;

   seq_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rst_out_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StHold: begin
            if (pll_locked) state_d = StCount;
         end
         StCount: begin
            if (!pll_locked) begin
               state_d = StHold;
            end else if (cnt_q == CNT_LAST) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRun: begin
            if (!pll_locked) state_d = StHold;
         end
         default: state_d = StHold;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StHold;
         cnt_q     <= '0;
         rst_out_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rst_out_q <= (state_q != StRun);
      end
   end

   // Lock loss clears the channels on the same edge that the sequencer drops
   // back to HOLD, so accumulation is qualified by the live lock as well.
   logic run;
   assign run     = (state_q == StRun) && pll_locked;
   assign rst_out = rst_out_q;

   // ------------------------------------------------------------------------
   // Config port: one-entry pending register, applied on the following cycle
   // ------------------------------------------------------------------------
   logic              pend_valid_q;
   logic [CH_W-1:0]   pend_ch_q;
   logic              pend_bc_q;
   logic [ACC_W-1:0]  pend_inc_q;
   logic              pend_en_q;
   logic              pend_pr_q;
   logic              accept;

   assign cfg_ready = !pend_valid_q;
   assign accept    = cfg_valid && cfg_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_ch_q    <= '0;
         pend_bc_q    <= 1'b0;
         pend_inc_q   <= '0;
         pend_en_q    <= 1'b0;
         pend_pr_q    <= 1'b0;
      end else begin
         if (pend_valid_q) begin
            pend_valid_q <= 1'b0;
         end else if (accept) begin
            pend_valid_q <= 1'b1;
            pend_ch_q    <= cfg_ch;
            pend_bc_q    <= cfg_broadcast;
            pend_inc_q   <= cfg_inc;
            pend_en_q    <= cfg_en;
            pend_pr_q    <= cfg_phase_reset;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Phase accumulators
   // ------------------------------------------------------------------------
   logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [NUM_CH-1:0][ACC_W-1:0] inc_q, inc_d;
   logic [NUM_CH-1:0]            en_q, en_d;
   logic [NUM_CH-1:0]            strobe_q, strobe_d;
   logic [ACC_W:0]               sum;

   always_comb begin
      acc_d    = acc_q;
      inc_d    = inc_q;
      en_d     = en_q;
      strobe_d = '0;
      sum      = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         sum = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
         // Out-of-range cfg_ch never matches, so such requests are dropped.
         if (pend_valid_q && (pend_bc_q || (32'(pend_ch_q) == i))) begin
            // Apply replaces this cycle's accumulate; new inc takes effect next.
            inc_d[i] = pend_inc_q;
            en_d[i]  = pend_en_q;
            if (pend_pr_q || !run) acc_d[i] = '0;
         end else if (run && en_q[i]) begin
            acc_d[i]    = sum[ACC_W-1:0];
            strobe_d[i] = sum[ACC_W];
         end else begin
            acc_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q    <= '0;
         inc_q    <= '0;
         en_q     <= '0;
         strobe_q <= '0;
      end else begin
         acc_q    <= acc_d;
         inc_q    <= inc_d;
         en_q     <= en_d;
         strobe_q <= strobe_d;
      end
   end

   assign strobe = strobe_q;

endmodule

// File: tb/tb_clock_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_clock_strobe_gen
//
// Directed bench for clock_strobe_gen (NUM_CH=3, ACC_W=24, RESET_HOLD=16).
// A behavioural model tracks consecutive locked cycles and per-channel phase
// arithmetic; a compare process checks every cycle, and the directed
// sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_clock_strobe_gen;

   localparam int unsigned NUM_CH     = 3;
   localparam int unsigned ACC_W      = 24;
   localparam int unsigned RESET_HOLD = 16;
   localparam int unsigned CH_W       = 2;
   localparam longint      MOD        = longint'(1) << ACC_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              pll_locked;
   logic              rst_out;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic              cfg_broadcast;
   logic [ACC_W-1:0]  cfg_inc;
   logic              cfg_en;
   logic              cfg_phase_reset;
   logic [NUM_CH-1:0] strobe;

   always #5 clock = ~clock;

   clock_strobe_gen #(
      .NUM_CH     (NUM_CH),
      .ACC_W      (ACC_W),
      .RESET_HOLD (RESET_HOLD)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pll_locked      (pll_locked),
      .rst_out         (rst_out),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_ch          (cfg_ch),
      .cfg_broadcast   (cfg_broadcast),
      .cfg_inc         (cfg_inc),
      .cfg_en          (cfg_en),
      .cfg_phase_reset (cfg_phase_reset),
      .strobe          (strobe)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: the sequencer is RUN once lock has been seen on more
   // than RESET_HOLD consecutive edges; channels are plain modular sums.
   // ------------------------------------------------------------------------
   bit                model_ok = 1'b0;
   int                lock_run;
   logic              m_rst_out;
   logic [NUM_CH-1:0] m_strobe;
   longint            m_acc [NUM_CH];
   longint            m_inc [NUM_CH];
   bit                m_en  [NUM_CH];
   bit                m_pend;
   int                m_p_ch;
   bit                m_p_bc, m_p_en, m_p_pr;
   longint            m_p_inc;
   bit                m_active, m_seq_run;
   longint            m_sum;

   always @(posedge clock) begin
      if (reset) begin
         model_ok  = 1'b1;
         lock_run  = 0;
         m_rst_out = 1'b1;
         m_strobe  = '0;
         m_pend    = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = 0;
            m_en[i]  = 1'b0;
         end
      end else if (model_ok) begin
         m_seq_run = (lock_run > RESET_HOLD);
         m_active  = m_seq_run && pll_locked;
         m_rst_out = !m_seq_run;
         for (int i = 0; i < NUM_CH; i++) begin
            if (m_pend && (m_p_bc || m_p_ch == i)) begin
               m_inc[i] = m_p_inc;
               m_en[i]  = m_p_en;
               if (m_p_pr || !m_active) m_acc[i] = 0;
               m_strobe[i] = 1'b0;
            end else if (m_active && m_en[i]) begin
               m_sum       = m_acc[i] + m_inc[i];
               m_strobe[i] = (m_sum >= MOD);
               m_acc[i]    = m_sum % MOD;
            end else begin
               m_acc[i]    = 0;
               m_strobe[i] = 1'b0;
            end
         end
         if (m_pend) begin
            m_pend = 1'b0;
         end else if (cfg_valid) begin
            m_pend  = 1'b1;
            m_p_ch  = int'(cfg_ch);
            m_p_bc  = cfg_broadcast;
            m_p_inc = longint'(cfg_inc);
            m_p_en  = cfg_en;
            m_p_pr  = cfg_phase_reset;
         end
         if (!pll_locked) lock_run = 0;
         else if (lock_run <= RESET_HOLD) lock_run = lock_run + 1;
      end
   end

   always @(posedge clock) begin
      #1;
      if (model_ok) begin
         check("rst_out", {63'd0, rst_out}, {63'd0, m_rst_out});
         check("cfg_ready", {63'd0, cfg_ready}, {63'd0, !m_pend});
         check("strobe", 64'(strobe), 64'(m_strobe));
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 2 time units after the rising edge)
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // Returns just after the accept edge.
   task automatic send(input int ch, input bit bc, input longint inc, input bit en,
                       input bit pr);
      int n;
      cfg_ch          = CH_W'(ch);
      cfg_broadcast   = bc;
      cfg_inc         = ACC_W'(inc);
      cfg_en          = en;
      cfg_phase_reset = pr;
      cfg_valid       = 1'b1;
      n = 0;
      while (!cfg_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_wait: cfg_ready low for %0d cycles, required high", n);
      end
      tick();
      cfg_valid = 1'b0;
   endtask

   // Counts edges from the first locked edge until rst_out is seen low.
   task automatic wait_release(output int n);
      n = 0;
      while (rst_out && n < 40) begin
         tick();
         n++;
      end
   endtask

   typedef struct {
      int     ch;
      longint inc;
      bit     pr;
   } req_t;

   int          n, idx;
   int          c0, c1, last0, last1, p0min, p0max, p1min, p1max;
   logic [7:0]  ready_bits;
   bit          acc_now;
   req_t        reqs [4];

   initial begin
      reset = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
      cfg_broadcast = 1'b0; cfg_inc = '0; cfg_en = 1'b0; cfg_phase_reset = 1'b0;
      #2;
      repeat (2) tick();
      check("reset_rst_out", {63'd0, rst_out}, 64'd1);
      check("reset_cfg_ready", {63'd0, cfg_ready}, 64'd1);
      check("reset_strobe", 64'(strobe), 64'd0);
      reset = 1'b0;
      tick();

      // Program channels while still held in reset.
      send(0, 1'b0, 64'h400000, 1'b1, 1'b0);
      send(1, 1'b0, 64'h555556, 1'b1, 1'b0);
      tick();

      // Lock glitch: 10 locked cycles, one unlocked, then a fresh count.
      pll_locked = 1'b1;
      repeat (10) tick();
      pll_locked = 1'b0;
      tick();
      check("glitch_hold", {63'd0, rst_out}, 64'd1);
      pll_locked = 1'b1;
      wait_release(n);
      check("glitch_release_edges", 64'(n), 64'd18);

      // Rate check over 1200 cycles.
      c0 = 0; c1 = 0; last0 = -1; last1 = -1;
      p0min = 1000; p0max = 0; p1min = 1000; p1max = 0;
      for (int k = 0; k < 1200; k++) begin
         tick();
         if (strobe[0]) begin
            if (last0 >= 0) begin
               if (k - last0 < p0min) p0min = k - last0;
               if (k - last0 > p0max) p0max = k - last0;
            end
            last0 = k;
            c0++;
         end
         if (strobe[1]) begin
            if (last1 >= 0) begin
               if (k - last1 < p1min) p1min = k - last1;
               if (k - last1 > p1max) p1max = k - last1;
            end
            last1 = k;
            c1++;
         end
      end
      check("rate_ch0_count", 64'(c0), 64'd300);
      check("rate_ch0_pmin", 64'(p0min), 64'd4);
      check("rate_ch0_pmax", 64'(p0max), 64'd4);
      check("rate_ch1_count_in_399_401", {63'd0, (c1 >= 399 && c1 <= 401)}, 64'd1);
      check("rate_ch1_pmin", 64'(p1min), 64'd3);
      check("rate_ch1_pmax", 64'(p1max), 64'd3);

      // Lock loss: strobes clear on the edge, rst_out one edge later.
      pll_locked = 1'b0;
      tick();
      check("lockloss_rst_out_e", {63'd0, rst_out}, 64'd0);
      check("lockloss_strobe_e", 64'(strobe), 64'd0);
      tick();
      check("lockloss_rst_out_e1", {63'd0, rst_out}, 64'd1);
      pll_locked = 1'b1;
      wait_release(n);
      check("lock_release_edges", 64'(n), 64'd18);

      // Back-to-back requests with cfg_valid held high.
      reqs[0] = '{ch: 0, inc: 64'h200000, pr: 1'b1};
      reqs[1] = '{ch: 1, inc: 64'h100000, pr: 1'b1};
      reqs[2] = '{ch: 2, inc: 64'h300000, pr: 1'b0};
      reqs[3] = '{ch: 0, inc: 64'h400000, pr: 1'b0};
      idx = 0;
      for (int k = 0; k < 8; k++) begin
         if (idx < 4) begin
            cfg_valid       = 1'b1;
            cfg_ch          = CH_W'(reqs[idx].ch);
            cfg_broadcast   = 1'b0;
            cfg_inc         = ACC_W'(reqs[idx].inc);
            cfg_en          = 1'b1;
            cfg_phase_reset = reqs[idx].pr;
         end else begin
            cfg_valid = 1'b0;
         end
         ready_bits[7-k] = cfg_ready;
         acc_now = cfg_valid && cfg_ready;
         tick();
         if (acc_now) idx++;
      end
      cfg_valid = 1'b0;
      check("handshake_ready_pattern", 64'(ready_bits), 64'hAA);
      check("handshake_accepted", 64'(idx), 64'd4);
      repeat (37) tick();

      // Broadcast with phase reset aligns every channel to period 2.
      send(0, 1'b1, 64'h800000, 1'b1, 1'b1);
      tick();
      check("bc_apply", 64'(strobe), 64'd0);
      tick();
      check("bc_apply_p1", 64'(strobe), 64'd0);
      tick();
      check("bc_first", 64'(strobe), 64'h7);
      tick();
      check("bc_gap", 64'(strobe), 64'd0);
      tick();
      check("bc_second", 64'(strobe), 64'h7);

      // Out-of-range channel is discarded, even with phase reset requested.
      send(3, 1'b0, 64'h000000, 1'b0, 1'b1);
      tick();
      check("oor_no_change", 64'(strobe), 64'h7);
      tick();

      // Disable channel 1 only.
      send(1, 1'b0, 64'h800000, 1'b0, 1'b0);
      tick();
      tick();
      check("disable_ch1_a", 64'(strobe), 64'h5);
      check("disable_ch1_acc", 64'(dut.acc_q[1]), 64'd0);
      tick();
      tick();
      check("disable_ch1_b", 64'(strobe), 64'h5);

      // Lock loss on the apply cycle: config lands, accumulators clear.
      send(2, 1'b0, 64'h200000, 1'b1, 1'b0);
      pll_locked = 1'b0;
      tick();
      check("lockloss_apply_inc", 64'(dut.inc_q[2]), 64'h200000);
      check("lockloss_apply_strobe", 64'(strobe), 64'd0);
      tick();
      pll_locked = 1'b1;
      wait_release(n);
      check("lockloss_apply_release", 64'(n), 64'd18);
      repeat (20) tick();

      // Reset while a request is pending drops the request.
      send(0, 1'b1, 64'h400000, 1'b1, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      c0 = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (strobe != '0) c0++;
      end
      check("reset_drops_pending", 64'(c0), 64'd0);
      check("relock_after_reset", {63'd0, rst_out}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clock_strobe_gen.md
# clock_strobe_gen

Parametrised clock-enable generator that sits directly behind the board PLL wrapper. It sequences a clean design reset from the PLL lock signal and produces NUM_CH independent fractional-rate strobe outputs. Each strobe comes from a phase accumulator that can be reprogrammed at run time through a valid/ready config port. Downstream logic runs on the single PLL clock and uses the strobes as clock enables, replacing per-rate PLL variants.

## Interface
- NUM_CH, 4, number of strobe channels (1..16)
- ACC_W, 24, phase accumulator width in bits (8..32)
- RESET_HOLD, 16, cycles of continuous lock required before rst_out releases (>=1)
- CH_W, $clog2(NUM_CH) min 1, width of cfg_ch (derived, not overridden)

Ports:
- clock  in  1  PLL output clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL lock indication, already synchronised to clock
- rst_out  out  1  design reset, active-high, synchronous to clock
- cfg_valid  in  1  config request
- cfg_ready  out  1  config port can accept
- cfg_ch  in  CH_W  target channel
- cfg_broadcast  in  1  apply to all channels, ignore cfg_ch
- cfg_inc  in  ACC_W  phase increment
- cfg_en  in  1  channel enable
- cfg_phase_reset  in  1  clear target accumulator(s) when applied
- strobe  out  NUM_CH  one-cycle clock-enable pulses, bit i = channel i

## Operation
- Reset sequencer, states HOLD, COUNT, RUN:
  - HOLD: rst_out=1, counter=0; pll_locked=1 -> COUNT.
  - COUNT: counter increments each cycle; pll_locked=0 -> HOLD; counter==RESET_HOLD-1 with lock -> RUN.
  - RUN: rst_out=0; pll_locked=0 -> HOLD.
  - rst_out is registered from the state and equals (state!=RUN) one cycle late.
- Channels: per channel acc[ACC_W], inc[ACC_W], en.
  - When state==RUN and en=1: {carry,acc} <= acc + inc at ACC_W+1 bits. The accumulator wraps modulo 2^ACC_W. strobe[i] <= carry.
  - When state!=RUN or en=0: acc <= 0, strobe[i] <= 0.
  - Strobe rate = f_clock * inc / 2^ACC_W. inc=0 never strobes.
- Config handshake:
  - A request is accepted on a cycle where cfg_valid && cfg_ready. The fields are latched into a one-entry pending register and cfg_ready drops.
  - On the next cycle the pending entry is applied: inc<=cfg_inc and en<=cfg_en, plus acc<=0 if cfg_phase_reset. Apply targets all channels if cfg_broadcast, otherwise cfg_ch.
  - cfg_ready returns high the cycle after apply.
  - cfg_ch>=NUM_CH without broadcast is accepted and discarded, with no state change.
  - Config is accepted in any sequencer state. inc and en persist across lock loss. acc does not persist (see above).
  - An apply cycle overrides that cycle's accumulate for the targeted channel. The new inc is first used on the following cycle.
- Reset: state=HOLD, counter=0, rst_out=1, strobe=0, all acc/inc/en=0, pending empty, cfg_ready=1 on the first cycle after reset deasserts. Reset asserted mid-operation has the same effect on the next edge.

## Timing
- Lock to release: pll_locked rises at edge E. State is RUN after edge E+RESET_HOLD. rst_out=0 after edge E+RESET_HOLD+1.
- Lock loss: pll_locked low at edge E forces state=HOLD and all strobes and acc cleared at E. rst_out=1 after E+1.
- Config latency: accept at edge T, apply at T+1, cfg_ready=1 again after T+1. Sustained throughput is one request per 2 cycles.
- Strobe latency: the strobe is registered, so it appears one cycle after the accumulate that overflows.
- Example: inc=2^(ACC_W-2), acc=0, RUN, en=1 gives the first strobe on the 4th enabled cycle, then every 4 cycles.
- Simultaneous events:
  - lock loss on an apply cycle: the config is still applied (inc/en), and acc is cleared.
  - reset with a pending request: the request is dropped.

## Test plan
- Lock sequence, RESET_HOLD=16: assert pll_locked at cycle 10 -> rst_out falls at cycle 27. Drop lock at cycle 40 -> rst_out=1 at 41 and strobes 0 from 40.
- Lock glitch: lock 1 for 10 cycles, 0 for 1, then 1 -> rst_out stays 1 until 16 uninterrupted locked cycles plus 1.
- Rate check, ACC_W=24, channel 0 inc=0x400000, channel 1 inc=0x555556, both enabled, RUN -> over 1200 cycles, ch0 pulses exactly 300 times with period 4; ch1 pulses 400±1 times with periods of 3, never 2 or 4.
- Handshake: hold cfg_valid high with 4 back-to-back requests -> cfg_ready toggles 1,0,1,0. Each apply lands one cycle after its accept. No request is lost or duplicated.
- Broadcast with phase reset: channels 0..3 at different accumulator phases, broadcast inc=0x800000, en=1, phase_reset=1 -> all four strobe on the same cycles, every 2 cycles, starting 2 cycles after apply.
- Out-of-range and disable: NUM_CH=3, cfg_ch=3 -> accepted and no channel changes. Then cfg_ch=1, en=0 -> strobe[1]=0 from apply+1 and acc[1]=0. Other channels are unaffected.
